// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a start/done handshake: add/sub/slt finish in one cycle,
// mul runs as a WIDTH-iteration shift-add so the stall logic can hold the PC meanwhile.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt_bit;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH-1:0] acc_next;

    // Single-cycle datapath evaluated straight from the operands presented with start.
    always_comb begin
        sum     = src_a + src_b;
        diff    = src_a - src_b;
        ovf_add = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
        ovf_sub = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
        slt_bit = diff[WIDTH-1] ^ ovf_sub;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ALU_control)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = ovf_add;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = ovf_sub;
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            end
            default: begin
                alu_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
    end

    // Control FSM; all outputs are registered so downstream stall logic sees clean levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            counter  <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    if (start) begin
                        ready <= 1'b0;
                        if (ALU_control == OP_MUL) begin
                            acc     <= '0;
                            mcand   <= src_a;
                            mplier  <= src_b;
                            counter <= '0;
                            state   <= S_MUL;
                        end else begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            illegal  <= alu_ill;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                    // Fixed WIDTH iterations keep mul latency independent of the operands.
                    if (counter == LAST_ITER) begin
                        result   <= acc_next;
                        zero     <= (acc_next == '0);
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       ALU_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    int n_compared = 0;
    int n_failed   = 0;

    alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_control (ALU_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: signed arithmetic on wide integers, no bit-level tricks.
    function automatic void model(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output logic ill,
                                  output int lat);
        longint signed sa;
        longint signed sb;
        longint signed wide;
        logic [63:0]   prod;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        r    = '0;
        ov   = 1'b0;
        ill  = 1'b0;
        lat  = 1;
        case (ctl)
            3'b010: begin
                wide = sa + sb;
                r    = 32'(wide);
                ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'b100: begin
                wide = sa - sb;
                r    = 32'(wide);
                ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'b110: r = (sa < sb) ? 32'd1 : 32'd0;
            3'b101: begin
                prod = {32'b0, a} * {32'b0, b};
                r    = prod[31:0];
                lat  = WIDTH + 1;
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Waits for ready, issues one op, scrambles the inputs after acceptance and
    // returns the cycles until done plus how many of those had ready low.
    task automatic run_op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy);
        int guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start       = 1'b1;
        ALU_control = ctl;
        src_a       = a;
        src_b       = b;
        @(negedge clk);
        start       = 1'b0;
        ALU_control = 3'($urandom);
        src_a       = $urandom;
        src_b       = $urandom;
        lat  = 1;
        busy = ready ? 0 : 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!ready) busy++;
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        start       = 1'b0;
        ALU_control = 3'b000;
        src_a       = '0;
        src_b       = '0;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({ready, done, result, zero, overflow, illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_failed++;
            $display("[TB] FAIL reset_state: got rdy=%b done=%b res=%h z=%b ov=%b ill=%b expected 1 0 0 1 0 0",
                     ready, done, result, zero, overflow, illegal);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_compared++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL reset_release: got rdy=%b done=%b expected rdy=1 done=0", ready, done);
        end
    endtask

    // Table of directed cases covering the overflow and signed-compare corners.
    task automatic test_directed;
        logic [2:0]  ctl_t [9];
        logic [31:0] a_t   [9];
        logic [31:0] b_t   [9];
        logic [31:0] exp_r;
        logic        exp_ov;
        logic        exp_ill;
        int          exp_lat;
        int          lat;
        int          busy;
        ctl_t = '{3'b010, 3'b010, 3'b100, 3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b011};
        a_t   = '{32'd5, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd3,
                  32'd12345, 32'hFFFFFFFF, 32'd9};
        b_t   = '{32'd7, 32'd1, 32'd1, 32'd1, 32'h7FFFFFFF, 32'd3, 32'd678, 32'd2, 32'd4};
        for (int i = 0; i < 9; i++) begin
            model(ctl_t[i], a_t[i], b_t[i], exp_r, exp_ov, exp_ill, exp_lat);
            run_op(ctl_t[i], a_t[i], b_t[i], lat, busy);
            n_compared++;
            if (lat !== exp_lat || busy !== exp_lat) begin
                n_failed++;
                $display("[TB] FAIL directed_latency[%0d]: got lat=%0d busy=%0d expected %0d", i, lat, busy, exp_lat);
            end
            n_compared++;
            if ({result, zero, overflow, illegal} !== {exp_r, exp_r == 32'h0, exp_ov, exp_ill}) begin
                n_failed++;
                $display("[TB] FAIL directed_result[%0d]: got %h z=%b ov=%b ill=%b expected %h z=%b ov=%b ill=%b",
                         i, result, zero, overflow, illegal, exp_r, exp_r == 32'h0, exp_ov, exp_ill);
            end
        end
    endtask

    task automatic test_busy_start;
        int   dones;
        int   done_at;
        logic [31:0] res_at_done;
        int   guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1; ALU_control = 3'b101; src_a = 32'd1000; src_b = 32'd77;
        @(negedge clk);
        start = 1'b1; ALU_control = 3'b010; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; done_at = 0; res_at_done = '0;
        for (int c = 2; c <= 60; c++) begin
            if (done) begin
                dones++;
                done_at     = c;
                res_at_done = result;
            end
            @(negedge clk);
        end
        n_compared++;
        if (dones !== 1 || done_at !== WIDTH + 1) begin
            n_failed++;
            $display("[TB] FAIL busy_done_count: got %0d pulses at cycle %0d expected 1 at %0d", dones, done_at, WIDTH + 1);
        end
        n_compared++;
        if (res_at_done !== 32'd77000 || result !== 32'd77000) begin
            n_failed++;
            $display("[TB] FAIL busy_result: got %h then %h expected %h", res_at_done, result, 32'd77000);
        end
    endtask

    task automatic test_reset_mid_mul;
        int   lat;
        int   busy;
        int   seen_done;
        start = 1'b1; ALU_control = 3'b101; src_a = 32'd123; src_b = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (ready !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || done !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL midmul_reset: got rdy=%b res=%h z=%b done=%b expected 1 0 1 0", ready, result, zero, done);
        end
        seen_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        n_compared++;
        if (seen_done !== 0 || result !== 32'h0) begin
            n_failed++;
            $display("[TB] FAIL midmul_no_done: got %0d pulses res=%h expected 0 pulses res=0", seen_done, result);
        end
        run_op(3'b010, 32'd2, 32'd2, lat, busy);
        n_compared++;
        if (result !== 32'd4 || lat !== 1) begin
            n_failed++;
            $display("[TB] FAIL midmul_followup_add: got %h lat=%0d expected 4 lat=1", result, lat);
        end
    endtask

    // Random ops issued back to back, also checking ready returns right after done
    // and that results hold through idle cycles.
    task automatic test_back_to_back;
        logic [2:0]  codes [5];
        logic [2:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_ov;
        logic        exp_ill;
        int          exp_lat;
        int          lat;
        int          busy;
        int          idle;
        codes = '{3'b010, 3'b100, 3'b110, 3'b101, 3'b000};
        for (int i = 0; i < 120; i++) begin
            ctl = codes[$urandom_range(4)];
            if (ctl == 3'b000) ctl = 3'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(3) == 0) b = a;
            if ($urandom_range(3) == 0) a = {$urandom_range(1), 31'h7FFFFFFF} ^ {1'b0, 31'($urandom_range(3))};
            model(ctl, a, b, exp_r, exp_ov, exp_ill, exp_lat);
            run_op(ctl, a, b, lat, busy);
            n_compared++;
            if ({result, zero, overflow, illegal} !== {exp_r, exp_r == 32'h0, exp_ov, exp_ill} || lat !== exp_lat) begin
                n_failed++;
                $display("[TB] FAIL random[%0d] ctl=%b a=%h b=%h: got %h z=%b ov=%b ill=%b lat=%0d expected %h z=%b ov=%b ill=%b lat=%0d",
                         i, ctl, a, b, result, zero, overflow, illegal, lat,
                         exp_r, exp_r == 32'h0, exp_ov, exp_ill, exp_lat);
            end
            @(negedge clk);
            n_compared++;
            if (ready !== 1'b1 || done !== 1'b0) begin
                n_failed++;
                $display("[TB] FAIL b2b_ready[%0d]: got rdy=%b done=%b expected rdy=1 done=0", i, ready, done);
            end
            idle = $urandom_range(2);
            repeat (idle) @(negedge clk);
            n_compared++;
            if (result !== exp_r) begin
                n_failed++;
                $display("[TB] FAIL hold[%0d]: got %h expected %h", i, result, exp_r);
            end
        end
    endtask

    initial begin
        $display("[TB] starting alu_exec_unit bench");
        test_reset();
        test_directed();
        test_busy_start();
        test_reset_mid_mul();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
